// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding and
// the register-number width used by the hazard comparator.
package pipe_ctrl_pkg;

    localparam int REG_NUM_W = 3;
    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard comparator: flags an ID-stage read of a register that the
// EX-stage load has not yet fetched from main memory.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_NUM_W-1:0] rs_a_id,
    input  logic [REG_NUM_W-1:0] rs_b_id,
    input  logic                 use_a_id,
    input  logic                 use_b_id,
    input  logic [REG_NUM_W-1:0] regwrite_adr_ex,
    input  logic                 regwrite_ex,
    input  logic                 from_main_mem_ex,
    output logic                 load_use
);

    logic match_a;
    logic match_b;

    assign match_a  = use_a_id && (rs_a_id == regwrite_adr_ex);
    assign match_b  = use_b_id && (rs_b_id == regwrite_adr_ex);
    assign load_use = regwrite_ex && from_main_mem_ex && (match_a || match_b);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory-wait freeze, halt/resume, branch
// flush and load-use stall, plus a saturating count of PC-stall cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_NUM_W-1:0]   rs_a_id,
    input  logic [REG_NUM_W-1:0]   rs_b_id,
    input  logic                   use_a_id,
    input  logic                   use_b_id,
    input  logic [REG_NUM_W-1:0]   regwrite_adr_ex,
    input  logic                   regwrite_ex,
    input  logic                   from_main_mem_ex,
    input  logic                   branch_taken_ex,
    input  logic                   mem_access_mem,
    input  logic                   is_halt,
    input  logic                   resume,
    output logic                   pc_en,
    output logic                   en_ifid,
    output logic                   en_idex,
    output logic                   en_exmem,
    output logic                   en_memwb,
    output logic                   flush_ifid,
    output logic                   flush_idex,
    output logic                   flush_exmem,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [2:0] WAIT_LOAD = (MEM_WAIT > 0) ? 3'(MEM_WAIT - 1) : 3'd0;

    ctrl_state_t state;
    logic [2:0]  wcnt;
    logic        mem_done;
    logic        load_use;
    logic        mem_stall;

    hazard_detect u_hazard_detect (
        .rs_a_id          (rs_a_id),
        .rs_b_id          (rs_b_id),
        .use_a_id         (use_a_id),
        .use_b_id         (use_b_id),
        .regwrite_adr_ex  (regwrite_adr_ex),
        .regwrite_ex      (regwrite_ex),
        .from_main_mem_ex (from_main_mem_ex),
        .load_use         (load_use)
    );

    // mem_done stops the access that just finished from stalling a second time
    assign mem_stall = (MEM_WAIT > 0) && (state == RUN) && mem_access_mem && !mem_done;

    always_comb begin
        pc_en       = 1'b1;
        en_ifid     = 1'b1;
        en_idex     = 1'b1;
        en_exmem    = 1'b1;
        en_memwb    = 1'b1;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        if (!reset) begin
            pc_en       = 1'b0;
            en_ifid     = 1'b0;
            en_idex     = 1'b0;
            en_exmem    = 1'b0;
            en_memwb    = 1'b0;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
        end else if ((state == MEMWAIT) || ((state == HALTED) && !resume) ||
                     ((state == RUN) && (mem_stall || is_halt))) begin
            pc_en    = 1'b0;
            en_ifid  = 1'b0;
            en_idex  = 1'b0;
            en_exmem = 1'b0;
            en_memwb = 1'b0;
        end else if (state == RUN) begin
            if (branch_taken_ex) begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                en_ifid    = 1'b0;
                flush_idex = 1'b1;
            end
        end
    end

    // Entry cycle counts as the first frozen cycle, so MEMWAIT leaves when wcnt reaches one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wcnt     <= 3'd0;
            mem_done <= 1'b0;
            halted   <= 1'b0;
        end else begin
            if (en_exmem) begin
                mem_done <= 1'b0;
            end
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        wcnt <= WAIT_LOAD;
                        if (MEM_WAIT > 1) begin
                            state <= MEMWAIT;
                        end else begin
                            mem_done <= 1'b1;
                        end
                    end else if (is_halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                MEMWAIT: begin
                    wcnt <= wcnt - 3'd1;
                    if (wcnt <= 3'd1) begin
                        state    <= RUN;
                        mem_done <= 1'b1;
                    end
                end
                HALTED: begin
                    if (resume) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (!pc_en && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_WAIT, default 2, range 0..7: stall cycles per main-memory access in MEM.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; low = reset asserted.
REQ-004 rs_a_id, rs_b_id  in  3 each  source register numbers of the ID-stage instruction.
REQ-005 use_a_id, use_b_id  in  1 each  ID instruction reads rs_a_id / rs_b_id.
REQ-006 regwrite_adr_ex  in  3  destination register of the EX-stage instruction.
REQ-007 regwrite_ex, from_main_mem_ex  in  1 each  EX instruction writes a register; its data comes from main memory.
REQ-008 branch_taken_ex  in  1  branch resolved taken in EX.
REQ-009 mem_access_mem  in  1  EX/MEM register holds a load or store.
REQ-010 is_halt  in  1  EX/MEM register holds a halt.
REQ-011 resume  in  1  external restart request, sampled only in HALTED.
REQ-012 pc_en, en_ifid, en_idex, en_exmem, en_memwb  out  1 each  load enables for PC and pipeline registers.
REQ-013 flush_ifid, flush_idex, flush_exmem  out  1 each  synchronous clears; a flush overrides the matching enable in the pipeline register.
REQ-014 halted  out  1  high in HALTED state.
REQ-015 stall_cnt  out  16  count of cycles with pc_en=0 since reset.

Function
REQ-016 FSM states: RUN, MEMWAIT, HALTED; registered wait counter wcnt (3 bit) and flag mem_done.
REQ-017 Default (RUN, no event): all enables 1, all flushes 0, halted 0.
REQ-018 Priority, highest first: MEMWAIT/memory entry, HALTED/halt entry, branch flush, load-use stall.
REQ-019 RUN, mem_access_mem=1, mem_done=0, MEM_WAIT>0: all enables 0; wcnt<=MEM_WAIT-1; next MEMWAIT if MEM_WAIT>1, else stay RUN with mem_done<=1.
REQ-020 MEMWAIT: all enables 0; wcnt decrements; when wcnt=0 go RUN with mem_done<=1; total freeze = exactly MEM_WAIT cycles.
REQ-021 mem_done clears on any cycle with en_exmem=1; MEM_WAIT=0 disables memory stalls entirely.
REQ-022 RUN, is_halt=1 (memory rule not active): all enables 0, next HALTED.
REQ-023 HALTED, resume=0: all enables 0, halted 1; resume=1: all enables 1, halted 1 this cycle, next RUN (halt instruction advances out of EX/MEM; is_halt not re-sampled that cycle).
REQ-024 Branch (RUN, branch_taken_ex=1): all enables 1, flush_ifid=1, flush_idex=1.
REQ-025 Load-use hazard = regwrite_ex & from_main_mem_ex & ((use_a_id & rs_a_id==regwrite_adr_ex) | (use_b_id & rs_b_id==regwrite_adr_ex)); action: pc_en=0, en_ifid=0, flush_idex=1, others enabled; ignored when branch active.
REQ-026 flush_exmem asserted only while reset low; otherwise 0.
REQ-027 stall_cnt increments by 1 each cycle pc_en=0 (reset excluded), saturates at 16'hFFFF.
REQ-028 All outputs except stall_cnt and halted are combinational from state and inputs; no input-to-output latency beyond one comb path.

Reset
REQ-029 reset low: state RUN, wcnt 0, mem_done 0, stall_cnt 0, immediately, independent of clk.
REQ-030 While reset low: all enables 0, all flushes 1, halted 0.
REQ-031 Reset mid-MEMWAIT or HALTED abandons the operation; first cycle after release is RUN default.

Structure
REQ-032 Shared package holds the state enum (RUN, MEMWAIT, HALTED) and the 3-bit register-number width constant.
REQ-033 Hazard comparator is a combinational sub-module named hazard_detect; FSM, counter, stall_cnt stay in pipe_ctrl.

Verification
REQ-034 Load r3 in EX (regwrite_adr_ex=3, from_main_mem_ex=1), ID uses rs_a_id=3 -> one cycle pc_en=0, en_ifid=0, flush_idex=1; stall_cnt=1.
REQ-035 mem_access_mem=1 with MEM_WAIT=2 -> exactly 2 cycles all enables 0, then 1 cycle enables 1, no re-stall for same instruction.
REQ-036 branch_taken_ex=1 coincident with load-use match -> flush_ifid=flush_idex=1, pc_en=1, stall_cnt unchanged.
REQ-037 is_halt=1 -> halted=1 next cycle, enables 0 for 5 idle cycles; resume=1 -> enables 1 that cycle, RUN next, halted=0.
REQ-038 reset low during MEMWAIT (wcnt=1) -> outputs enables 0/flushes 1 at once; after release RUN defaults, stall_cnt=0.
REQ-039 Hold pc_en=0 for 65540 cycles -> stall_cnt saturates at 16'hFFFF.
